// File: rtl/practice_btn_conditioner.sv
// Three-channel push-button conditioner: 2-flop sync, per-channel debounce FSM,
// toggled level outputs plus per-channel press strobes and a combined change strobe.
`timescale 1ns/1ps

module practice_btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] btn,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic [2:0] press_pulse,
  output logic       changed
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_PRESS_CHK = 2'd1,
    S_HELD      = 2'd2,
    S_REL_CHK   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [2:0] sync1;
  logic [2:0] sync2;
  logic [2:0] qualify;
  logic [2:0] level;

  // NOTE: sequential state always uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours (the synchroniser depends on it).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

  for (genvar i = 0; i < 3; i++) begin : g_chan
    state_t           state;
    logic [CNT_W-1:0] cnt;

    // A press is accepted on the edge where the last required stable sample is seen.
    assign qualify[i] = (state == S_PRESS_CHK) && sync2[i] && (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state <= S_IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (sync2[i]) begin
              state <= S_PRESS_CHK;
              cnt   <= '0;
            end
          end
          S_PRESS_CHK: begin
            if (!sync2[i]) begin
              state <= S_IDLE;
              cnt   <= '0;
            end else if (cnt == CNT_LAST) begin
              state <= S_HELD;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          S_HELD: begin
            if (!sync2[i]) begin
              state <= S_REL_CHK;
              cnt   <= '0;
            end
          end
          S_REL_CHK: begin
            if (sync2[i]) begin
              state <= S_HELD;
              cnt   <= '0;
            end else if (cnt == CNT_LAST) begin
              state <= S_IDLE;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            state <= S_IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

  // Strobes and levels are registered from the same qualify term so they line up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      press_pulse <= '0;
      changed     <= 1'b0;
      level       <= '0;
    end else begin
      press_pulse <= qualify;
      changed     <= |qualify;
      level       <= level ^ qualify;
    end
  end

  assign a = level[0];
  assign b = level[1];
  assign c = level[2];

endmodule

// File: tb/tb_practice_btn_conditioner.sv
// Directed bench for practice_btn_conditioner with DEBOUNCE_CYCLES=4:
// reset, clean press, glitch, release bounce, simultaneous press, reset mid-count.
`timescale 1ns/1ps

module tb_practice_btn_conditioner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] btn;
  logic       a, b, c;
  logic [2:0] press_pulse;
  logic       changed;

  int checks   = 0;
  int failures = 0;

  practice_btn_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn        (btn),
    .a          (a),
    .b          (b),
    .c          (c),
    .press_pulse(press_pulse),
    .changed    (changed)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // lvl is {c,b,a}
  task automatic expect_out(input string tag, input logic [2:0] pp, input logic ch,
                            input logic [2:0] lvl);
    check({tag, "_pulse"},   {5'd0, press_pulse}, {5'd0, pp});
    check({tag, "_changed"}, {7'd0, changed},     {7'd0, ch});
    check({tag, "_level"},   {5'd0, c, b, a},     {5'd0, lvl});
  endtask

  // Advance one rising edge and settle 1 ns past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    btn   = 3'b000;

    // 1. Reset
    #1;
    expect_out("t1_async", 3'b000, 1'b0, 3'b000);
    for (int k = 1; k <= 5; k++) begin
      step();
      expect_out($sformatf("t1_rst_e%0d", k), 3'b000, 1'b0, 3'b000);
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      expect_out($sformatf("t1_post_e%0d", k), 3'b000, 1'b0, 3'b000);
    end

    // 2. Clean press on btn[0]: pulse on edge 7 only, a high from edge 7
    btn = 3'b001;
    for (int k = 1; k <= 20; k++) begin
      step();
      expect_out($sformatf("t2_e%0d", k), (k == 7) ? 3'b001 : 3'b000, (k == 7),
                 (k >= 7) ? 3'b001 : 3'b000);
    end

    // 3. Glitch on btn[1] for 3 cycles while btn[0] stays held
    btn = 3'b011;
    for (int k = 1; k <= 3; k++) begin
      step();
      expect_out($sformatf("t3_hi_e%0d", k), 3'b000, 1'b0, 3'b001);
    end
    btn = 3'b001;
    for (int k = 1; k <= 10; k++) begin
      step();
      expect_out($sformatf("t3_lo_e%0d", k), 3'b000, 1'b0, 3'b001);
    end

    // 4. Release with three 2-cycle rebounds, then a clean re-press
    for (int r = 0; r < 3; r++) begin
      btn = 3'b000;
      for (int k = 1; k <= 2; k++) begin
        step();
        expect_out($sformatf("t4_r%0d_lo_e%0d", r, k), 3'b000, 1'b0, 3'b001);
      end
      btn = 3'b001;
      for (int k = 1; k <= 2; k++) begin
        step();
        expect_out($sformatf("t4_r%0d_hi_e%0d", r, k), 3'b000, 1'b0, 3'b001);
      end
    end
    btn = 3'b000;
    for (int k = 1; k <= 10; k++) begin
      step();
      expect_out($sformatf("t4_rel_e%0d", k), 3'b000, 1'b0, 3'b001);
    end
    btn = 3'b001;
    for (int k = 1; k <= 20; k++) begin
      step();
      expect_out($sformatf("t4_press_e%0d", k), (k == 7) ? 3'b001 : 3'b000, (k == 7),
                 (k >= 7) ? 3'b000 : 3'b001);
    end
    btn = 3'b000;
    for (int k = 1; k <= 10; k++) begin
      step();
      expect_out($sformatf("t4_idle_e%0d", k), 3'b000, 1'b0, 3'b000);
    end

    // 5. Simultaneous press on btn[0] and btn[2]
    btn = 3'b101;
    for (int k = 1; k <= 12; k++) begin
      step();
      expect_out($sformatf("t5_e%0d", k), (k == 7) ? 3'b101 : 3'b000, (k == 7),
                 (k >= 7) ? 3'b101 : 3'b000);
    end
    btn = 3'b000;
    for (int k = 1; k <= 10; k++) begin
      step();
      expect_out($sformatf("t5_rel_e%0d", k), 3'b000, 1'b0, 3'b101);
    end

    // 6. Reset between edges 4 and 5 of a btn[2] press, button kept held
    btn = 3'b100;
    for (int k = 1; k <= 4; k++) begin
      step();
      expect_out($sformatf("t6_pre_e%0d", k), 3'b000, 1'b0, 3'b101);
    end
    #3;
    rst_n = 1'b0;
    #1;
    expect_out("t6_async", 3'b000, 1'b0, 3'b000);
    #1;
    rst_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      expect_out($sformatf("t6_e%0d", k), (k == 7) ? 3'b100 : 3'b000, (k == 7),
                 (k >= 7) ? 3'b100 : 3'b000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
